cpu_mem_arbiter: RTL and testbench

//  Shares the single 13-bit-address / 8-bit-data program/data memory between two masters:
//  m0 = CPU core (fetch/load/store), m1 = debug/program loader.

---
 rtl/cpu_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter
// Description : Round-robin arbiter sharing one program/data memory between
//               the CPU core (m0) and the debug/program loader (m1).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST = 3'(MEM_LAT - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_rr;
    logic                r_owner;
    logic                r_op_rd;
    logic [2:0]          r_lat;
    logic                r_gnt0, r_gnt1, r_done0, r_done1;
    logic                r_mem_rd, r_mem_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0, r_rdata1;
    logic                w_arb;
    logic                w_win;
    logic                w_last;

    // Arbitration is open whenever no access is in flight (IDLE or DONE).
    always_comb begin
        w_arb  = 1'b0;
        w_win  = 1'b0;
        w_last = 1'b0;
        w_next = r_state;
        w_arb  = (r_state != S_ACCESS) && (m0_req || m1_req);
        w_win  = (m0_req && m1_req) ? r_rr : m1_req;
        w_last = (r_state == S_ACCESS) && (r_lat == c_LAST);
        case (r_state)
            S_IDLE, S_DONE: w_next = w_arb ? S_ACCESS : S_IDLE;
            S_ACCESS:       w_next = w_last ? S_DONE : S_ACCESS;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_op_rd  <= 1'b0;
            r_lat    <= 3'd0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_arb) begin
                r_gnt0   <= ~w_win;
                r_gnt1   <= w_win;
                r_owner  <= w_win;
                r_rr     <= ~w_win;
                r_op_rd  <= w_win ? m1_rd : m0_rd;
                r_addr   <= w_win ? m1_addr : m0_addr;
                r_wdata  <= w_win ? m1_wdata : m0_wdata;
                r_mem_rd <= w_win ? m1_rd : m0_rd;
                r_mem_wr <= w_win ? ~m1_rd : ~m0_rd;
                r_lat    <= 3'd0;
            end else if (w_last) begin
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
                r_done0  <= ~r_owner;
                r_done1  <= r_owner;
                // Read data is sampled in the final strobe cycle, visible with done.
                if (r_op_rd && !r_owner) r_rdata0 <= mem_rdata;
                if (r_op_rd &&  r_owner) r_rdata1 <= mem_rdata;
            end else if (r_state == S_ACCESS) begin
                r_lat <= r_lat + 3'd1;
            end
        end
    end

    assign m0_gnt    = r_gnt0;
    assign m1_gnt    = r_gnt1;
    assign m0_done   = r_done0;
    assign m1_done   = r_done1;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_arbiter
// Description : Directed self-checking bench for cpu_mem_arbiter (MEM_LAT 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst;
    int          n_total;
    int          n_bad;

    // Instance A: MEM_LAT = 2, both masters exercised.
    logic        a_m0_req, a_m0_rd, a_m0_gnt, a_m0_done;
    logic [12:0] a_m0_addr;
    logic [7:0]  a_m0_wdata, a_m0_rdata;
    logic        a_m1_req, a_m1_rd, a_m1_gnt, a_m1_done;
    logic [12:0] a_m1_addr;
    logic [7:0]  a_m1_wdata, a_m1_rdata;
    logic        a_mem_rd, a_mem_wr, a_busy;
    logic [12:0] a_mem_addr;
    logic [7:0]  a_mem_wdata, a_mem_rdata;

    // Instance B: MEM_LAT = 1, m0 only.
    logic        b_m0_req, b_m0_rd, b_m0_gnt, b_m0_done;
    logic [12:0] b_m0_addr;
    logic [7:0]  b_m0_wdata, b_m0_rdata;
    logic        b_m1_req, b_m1_rd, b_m1_gnt, b_m1_done;
    logic [12:0] b_m1_addr;
    logic [7:0]  b_m1_wdata, b_m1_rdata;
    logic        b_mem_rd, b_mem_wr, b_busy;
    logic [12:0] b_mem_addr;
    logic [7:0]  b_mem_wdata, b_mem_rdata;

    // Memory model: data = low address byte XOR 0xF0.
    assign a_mem_rdata = a_mem_addr[7:0] ^ 8'hF0;
    assign b_mem_rdata = b_mem_addr[7:0] ^ 8'hF0;

    cpu_mem_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req(a_m0_req), .m0_rd(a_m0_rd), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_rd(a_m1_rd), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    cpu_mem_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_rd(b_m0_rd), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_rd(b_m1_rd), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b0;
        a_m0_req = 0; a_m0_rd = 1; a_m0_addr = '0; a_m0_wdata = '0;
        a_m1_req = 0; a_m1_rd = 1; a_m1_addr = '0; a_m1_wdata = '0;
        b_m0_req = 0; b_m0_rd = 1; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 0; b_m1_rd = 1; b_m1_addr = '0; b_m1_wdata = '0;
        tick();

        // 1: reset with both requests held
        a_m0_req = 1; a_m1_req = 1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt0", a_m0_gnt, 0);
            chk("rst_gnt1", a_m1_gnt, 0);
            chk("rst_strobe", {a_mem_rd, a_mem_wr}, 0);
            chk("rst_busy", a_busy, 0);
        end
        chk("rst_rdata0", a_m0_rdata, 0);
        chk("rst_rdata1", a_m1_rdata, 0);
        chk("rst_addr", a_mem_addr, 0);
        a_m0_req = 0; a_m1_req = 0;
        rst = 1'b0;
        tick();
        chk("idle_busy", a_busy, 0);

        // 2: single m0 read of 0x0155
        a_m0_req = 1; a_m0_rd = 1; a_m0_addr = 13'h0155;
        tick();
        chk("rd_gnt0", a_m0_gnt, 1);
        chk("rd_memrd1", a_mem_rd, 1);
        chk("rd_addr", a_mem_addr, 13'h0155);
        chk("rd_busy", a_busy, 1);
        a_m0_req = 0;
        tick();
        chk("rd_gnt0_low", a_m0_gnt, 0);
        chk("rd_memrd2", a_mem_rd, 1);
        chk("rd_done_early", a_m0_done, 0);
        tick();
        chk("rd_done0", a_m0_done, 1);
        chk("rd_rdata0", a_m0_rdata, 8'hA5);
        chk("rd_memrd_off", a_mem_rd, 0);
        chk("rd_m1_quiet", {a_m1_gnt, a_m1_done, a_m1_rdata}, 0);
        tick();
        chk("rd_idle", a_busy, 0);
        chk("rd_done_pulse", a_m0_done, 0);

        // 3: both held, alternating m0 write / m1 read (reset first so m0 leads)
        do_reset();
        a_m0_req = 1; a_m0_rd = 0; a_m0_addr = 13'h0010; a_m0_wdata = 8'h3C;
        a_m1_req = 1; a_m1_rd = 1; a_m1_addr = 13'h1FFF; a_m1_wdata = 8'h77;
        for (int s = 0; s < 4; s++) begin
            logic ev;
            ev = ((s % 2) == 0);
            tick();
            chk("rr_gnt0", a_m0_gnt, ev);
            chk("rr_gnt1", a_m1_gnt, !ev);
            chk("rr_memwr", a_mem_wr, ev);
            chk("rr_memrd", a_mem_rd, !ev);
            chk("rr_addr", a_mem_addr, ev ? 13'h0010 : 13'h1FFF);
            chk("rr_wdata", a_mem_wdata, ev ? 8'h3C : 8'h77);
            if (s == 3) begin
                a_m0_req = 0; a_m1_req = 0;
            end
            tick();
            chk("rr_strobe2", {a_mem_rd, a_mem_wr}, ev ? 2'b01 : 2'b10);
            chk("rr_nodone", {a_m0_done, a_m1_done}, 0);
            tick();
            chk("rr_done0", a_m0_done, ev);
            chk("rr_done1", a_m1_done, !ev);
            chk("rr_strobe_off", {a_mem_rd, a_mem_wr}, 0);
            chk("rr_rdata0", a_m0_rdata, 0);
            chk("rr_rdata1", a_m1_rdata, (s == 0) ? 8'h00 : 8'h0F);
        end
        tick();
        chk("rr_idle", a_busy, 0);

        // 4: m1 request withdrawn while m0 owns the bus
        a_m0_req = 1; a_m0_rd = 1; a_m0_addr = 13'h0020;
        tick();
        chk("wd_gnt0", a_m0_gnt, 1);
        a_m0_req = 0; a_m1_req = 1;
        tick();
        a_m1_req = 0;
        chk("wd_gnt1_a", a_m1_gnt, 0);
        tick();
        chk("wd_done0", a_m0_done, 1);
        chk("wd_rdata0", a_m0_rdata, 8'hD0);
        tick();
        chk("wd_gnt1_b", a_m1_gnt, 0);
        chk("wd_idle", a_busy, 0);
        tick();
        chk("wd_gnt1_c", a_m1_gnt, 0);
        chk("wd_strobe", {a_mem_rd, a_mem_wr}, 0);

        // 5: reset on the second access cycle
        a_m0_req = 1; a_m0_rd = 1; a_m0_addr = 13'h0030;
        tick();
        chk("ra_gnt0", a_m0_gnt, 1);
        a_m0_req = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ra_strobe", {a_mem_rd, a_mem_wr}, 0);
        chk("ra_nodone", a_m0_done, 0);
        chk("ra_busy", a_busy, 0);
        chk("ra_rdata0", a_m0_rdata, 0);
        tick();
        chk("ra_nodone2", a_m0_done, 0);
        a_m0_req = 1; a_m1_req = 1; a_m1_rd = 1;
        tick();
        chk("ra_rrptr_gnt0", a_m0_gnt, 1);
        chk("ra_rrptr_gnt1", a_m1_gnt, 0);
        a_m0_req = 0; a_m1_req = 0;
        tick();
        tick();
        tick();
        chk("ra_idle", a_busy, 0);

        // 6: MEM_LAT=1 back-to-back m0 reads
        b_m0_req = 1; b_m0_rd = 1; b_m0_addr = 13'h0001;
        tick();
        chk("l1_gnt_a", b_m0_gnt, 1);
        chk("l1_memrd_a", b_mem_rd, 1);
        chk("l1_addr_a", b_mem_addr, 13'h0001);
        b_m0_addr = 13'h0002;
        tick();
        chk("l1_done_a", b_m0_done, 1);
        chk("l1_rdata_a", b_m0_rdata, 8'hF1);
        chk("l1_memrd_off", b_mem_rd, 0);
        chk("l1_gnt_off", b_m0_gnt, 0);
        tick();
        chk("l1_gnt_b", b_m0_gnt, 1);
        chk("l1_memrd_b", b_mem_rd, 1);
        chk("l1_addr_b", b_mem_addr, 13'h0002);
        b_m0_req = 0;
        tick();
        chk("l1_done_b", b_m0_done, 1);
        chk("l1_rdata_b", b_m0_rdata, 8'hF2);
        tick();
        chk("l1_idle", b_busy, 0);
        chk("l1_nognt", b_m0_gnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
